alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  ID->EX operand stage feeding the 32-bit ArithmeticUnit (A, B, 4-bit AluOp).
//  - Captures decoded ops, resolves A/B through EX/MEM and MEM/WB forwarding, selects imm vs rt for B.
//  - Buffers up to two ops in a skid buffer with valid/ready on both sides, so upstream ready is a registered signal.
// PARAMETERS
//  DATA_W   32  operand/result width
//  REG_AW   5   register-address width
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  in_valid      in   1       decode presents an op
//  in_ready      out  1       stage accepts an op; registered
//  in_rs_addr    in   REG_AW  source A register number
//  in_rt_addr    in   REG_AW  source B register number
//  in_rs_data    in   DATA_W  register-file value for rs
//  in_rt_data    in   DATA_W  register-file value for rt
//  in_imm        in   DATA_W  already-extended immediate
//  in_alu_src    in   1       1: B=imm, 0: B=rt
//  in_alu_op     in   4       AluOp for the ALU
//  in_rd_addr    in   REG_AW  destination register
//  in_reg_write  in   1       op writes rd
//  flush         in   1       discard all buffered ops (branch redirect)
//  exmem_wr      in   1       EX/MEM writes exmem_rd
//  exmem_rd      in   REG_AW  EX/MEM destination
//  exmem_result  in   DATA_W  EX/MEM result
//  memwb_wr      in   1       MEM/WB writes memwb_rd
//  memwb_rd      in   REG_AW  MEM/WB destination
//  memwb_result  in   DATA_W  MEM/WB result
//  out_valid     out  1       head op valid toward EX
//  out_ready     in   1       EX consumes head op
//  alu_a         out  DATA_W  operand A of head op
//  alu_b         out  DATA_W  operand B of head op
//  alu_op        out  4       AluOp of head op
//  out_rd_addr   out  REG_AW  head destination
//  out_reg_write out  1       head writes rd
// BEHAVIOUR
//  - Reset: state EMPTY; in_ready=1; out_valid=0; alu_a, alu_b, out_rd_addr=0; alu_op=ALU_ADD; out_reg_write=0.
//  - FSM: EMPTY(0 ops), ONE(head), TWO(head+skid). Push = in_valid&in_ready; pop = out_valid&out_ready.
//    - EMPTY: push -> ONE.
//    - ONE: push&!pop -> TWO; pop&!push -> EMPTY; both -> ONE (new op becomes head).
//    - TWO: pop -> ONE (skid moves to head). No push is possible: in_ready=0.
//  - in_ready register is next-state != TWO. Latency in->out is 1 cycle; outputs come only from head flops.
//  - flush: next state EMPTY, in_ready=1. It beats a push in the same cycle (pushed op dropped). A pop in the flush cycle completes normally.
//  - Forward select per operand, addr!=0 only:
//    - exmem_wr&exmem_rd==addr -> exmem_result
//    - else memwb_wr&memwb_rd==addr -> memwb_result
//    - else register-file data
//    - EX/MEM has priority when both buses match.
//  - Capture: A=fwd(rs); B=in_alu_src ? in_imm : fwd(rt). Entry keeps rs/rt addr and b_is_imm.
//  - Refresh: every cycle a held entry is not popped, its A (and B if !b_is_imm) reloads from a matching forward bus, else holds. This applies to head and skid.
//  - Register 0 never forwards; a value of 0 comes from the register file.
//  - Pass-through fields (alu_op, rd, reg_write) are never modified.
// CONFIGURATION
//  - OPSTAGE_FWD_EN defined: forwarding and refresh as above.
//  - Undefined: A=in_rs_data, B=in_alu_src?in_imm:in_rt_data, no refresh. Forward ports remain present and are ignored. The hazard unit stalls instead.
// STRUCTURE
//  - Package mips_alu_pkg:
//    - ALU_ADD=4'b0000, ALU_SUB=4'b0010 (bit1 = invert B + carry-in), ALU_SLT=4'b1010 (bit3 = select sign result).
//    - opstage_state_t enum {EMPTY, ONE, TWO}.
//    - opstage_entry_t struct {a, b, rs, rt, b_is_imm, alu_op, rd, reg_write}.
//  - Sub-module opstage_fwd_mux: combinational addr/data/bus -> forwarded value, used for capture and refresh of each operand.
// TESTING
//  - Reset: assert rst mid-stream with TWO ops held -> same cycle out_valid=0, in_ready=1, alu_op=ALU_ADD; no op emerges afterwards.
//  - Stream: in_ready held, out_ready=1, rs=1 data 5, rt=2 data 7, ALU_SUB -> next cycle alu_a=5, alu_b=7, alu_op=4'b0010, one op per cycle.
//  - Skid: out_ready=0, push ops X then Y -> state TWO, in_ready=0 the following cycle. Then out_ready=1 -> X then Y on consecutive cycles, in_ready=1 after X pops.
//  - Forward priority (FWD_EN): rs=3, exmem 3/0x11, memwb 3/0x22 -> alu_a=0x11. Then memwb only -> 0x22. With rs=0 and both buses on r0 -> alu_a=in_rs_data.
//  - Refresh (FWD_EN): head held with rt=4, alu_src=0. Then exmem_wr rd=4 result 0xABCD -> next cycle alu_b=0xABCD. With alu_src=1 -> alu_b stays imm.
//  - Flush: TWO held plus in_valid=1, flush=1 -> next cycle out_valid=0, in_ready=1; no pushed or held op emitted.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared types and constants for the ID->EX operand stage: AluOp encodings,
// stage FSM states and the buffered-op entry layout.
package mips_alu_pkg;

  localparam int OP_DATA_W = 32;
  localparam int OP_REG_AW = 5;

  // bit1 inverts B and sets carry-in; bit3 selects the sign of the difference
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } opstage_state_t;

  typedef struct packed {
    logic [OP_DATA_W-1:0] a;
    logic [OP_DATA_W-1:0] b;
    logic [OP_REG_AW-1:0] rs;
    logic [OP_REG_AW-1:0] rt;
    logic                 b_is_imm;
    logic [3:0]           alu_op;
    logic [OP_REG_AW-1:0] rd;
    logic                 reg_write;
  } opstage_entry_t;

  localparam opstage_entry_t ENTRY_RESET = '{alu_op: ALU_ADD, default: '0};

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Forwarding select for one operand: EX/MEM beats MEM/WB, register 0 never
// forwards, otherwise the supplied default value passes through.
module opstage_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] dflt,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_wr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] value
);

  logic nonzero;
  assign nonzero = (addr != '0);

  always_comb begin
    value = dflt;
    if (nonzero && exmem_wr && (exmem_rd == addr)) begin
      value = exmem_result;
    end else if (nonzero && memwb_wr && (memwb_rd == addr)) begin
      value = memwb_result;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID->EX operand stage: two-entry skid buffer with registered in_ready.
// Forwarding and refresh of held operands are enabled by OPSTAGE_FWD_EN.
module alu_operand_stage
  import mips_alu_pkg::*;
#(
  parameter int DATA_W = OP_DATA_W,
  parameter int REG_AW = OP_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs_addr,
  input  logic [REG_AW-1:0] in_rt_addr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_alu_src,
  input  logic [3:0]        in_alu_op,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_wr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_reg_write
);

  opstage_state_t state, state_n;
  opstage_entry_t head, skid, head_n, skid_n;
  opstage_entry_t head_ref, skid_ref, cap;
  logic [DATA_W-1:0] cap_a, cap_rt;
  logic push, pop;

`ifdef OPSTAGE_FWD_EN
  logic [DATA_W-1:0] head_a_f, head_b_f, skid_a_f, skid_b_f;

  opstage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_cap_a (
    .addr(in_rs_addr), .dflt(in_rs_data),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .value(cap_a));

  opstage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_cap_b (
    .addr(in_rt_addr), .dflt(in_rt_data),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .value(cap_rt));

  // Held entries default to their own value, so a miss simply holds.
  opstage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_head_a (
    .addr(head.rs), .dflt(head.a),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .value(head_a_f));

  opstage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_head_b (
    .addr(head.rt), .dflt(head.b),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .value(head_b_f));

  opstage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_skid_a (
    .addr(skid.rs), .dflt(skid.a),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .value(skid_a_f));

  opstage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_skid_b (
    .addr(skid.rt), .dflt(skid.b),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .value(skid_b_f));

  always_comb begin
    head_ref   = head;
    head_ref.a = head_a_f;
    if (!head.b_is_imm) head_ref.b = head_b_f;
    skid_ref   = skid;
    skid_ref.a = skid_a_f;
    if (!skid.b_is_imm) skid_ref.b = skid_b_f;
  end
`else
  logic unused_fwd;

  assign cap_a      = in_rs_data;
  assign cap_rt     = in_rt_data;
  assign head_ref   = head;
  assign skid_ref   = skid;
  assign unused_fwd = ^{exmem_wr, exmem_rd, exmem_result,
                        memwb_wr, memwb_rd, memwb_result};
`endif

  always_comb begin
    cap           = ENTRY_RESET;
    cap.a         = cap_a;
    cap.b         = in_alu_src ? in_imm : cap_rt;
    cap.rs        = in_rs_addr;
    cap.rt        = in_rt_addr;
    cap.b_is_imm  = in_alu_src;
    cap.alu_op    = in_alu_op;
    cap.rd        = in_rd_addr;
    cap.reg_write = in_reg_write;
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready here is a pure flop.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_n = state;
    head_n  = head_ref;
    skid_n  = skid_ref;
    case (state)
      EMPTY: begin
        if (push) begin
          head_n  = cap;
          state_n = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_n = cap;
        end else if (push) begin
          skid_n  = cap;
          state_n = TWO;
        end else if (pop) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_n  = skid_ref;
          state_n = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
    if (flush) state_n = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      head     <= ENTRY_RESET;
      skid     <= ENTRY_RESET;
    end else begin
      state    <= state_n;
      in_ready <= (state_n != TWO);
      head     <= head_n;
      skid     <= skid_n;
    end
  end

  assign out_valid     = (state != EMPTY);
  assign alu_a         = head.a;
  assign alu_b         = head.b;
  assign alu_op        = head.alu_op;
  assign out_rd_addr   = head.rd;
  assign out_reg_write = head.reg_write;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage; build with
// +define+OPSTAGE_FWD_EN to also exercise forwarding and refresh.
module tb_alu_operand_stage;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam int EW = 32 + 32 + 4 + 5 + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic        in_alu_src, in_reg_write, flush;
  logic [3:0]  in_alu_op;
  logic        exmem_wr, memwb_wr;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_alu_src(in_alu_src), .in_alu_op(in_alu_op),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .flush(flush),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        imm;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
  } ment_t;

  ment_t          mq[$];
  logic [EW-1:0]  exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Operand value as the forwarding rules describe it, given current buses.
  function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] dflt);
    if (addr != 0 && exmem_wr && exmem_rd == addr) return exmem_result;
    if (addr != 0 && memwb_wr && memwb_rd == addr) return memwb_result;
    return dflt;
  endfunction

  // Reference model: a queue of at most two ops, advanced once per cycle.
  task automatic model_step();
    logic  pop, push;
    ment_t e;
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    pop  = (mq.size() > 0) && out_ready;
    push = in_valid && (mq.size() < 2);
    if (pop) begin
      e = mq.pop_front();
      exp_q.push_back({e.a, e.b, e.op, e.rd, e.rw});
    end
`ifdef OPSTAGE_FWD_EN
    foreach (mq[i]) begin
      mq[i].a = fwd(mq[i].rs, mq[i].a);
      if (!mq[i].imm) mq[i].b = fwd(mq[i].rt, mq[i].b);
    end
    e.a = fwd(in_rs_addr, in_rs_data);
    e.b = in_alu_src ? in_imm : fwd(in_rt_addr, in_rt_data);
`else
    e.a = in_rs_data;
    e.b = in_alu_src ? in_imm : in_rt_data;
`endif
    e.rs = in_rs_addr; e.rt = in_rt_addr; e.imm = in_alu_src;
    e.op = in_alu_op;  e.rd = in_rd_addr; e.rw = in_reg_write;
    if (flush) mq.delete();
    else if (push) mq.push_back(e);
  endtask

  // Monitor: compares every output transfer against the scoreboard.
  initial begin
    logic [EW-1:0] x;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output alu_a=%0h alu_op=%0h expected=none", alu_a, alu_op);
        end else begin
          x = exp_q.pop_front();
          chk("alu_a", 64'(alu_a), 64'(x[73:42]));
          chk("alu_b", 64'(alu_b), 64'(x[41:10]));
          chk("alu_op", 64'(alu_op), 64'(x[9:6]));
          chk("rd", 64'(out_rd_addr), 64'(x[5:1]));
          chk("reg_write", 64'(out_reg_write), 64'(x[0]));
        end
      end
    end
  end

  task automatic tick();
    #1;
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; flush = 0;
    exmem_wr = 0; memwb_wr = 0;
  endtask

  task automatic set_op(input logic [4:0] rs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic src,
                        input logic [3:0] op, input logic [4:0] rd);
    in_valid = 1; in_rs_addr = rs; in_rs_data = rsd; in_rt_addr = rt;
    in_rt_data = rtd; in_imm = imm; in_alu_src = src; in_alu_op = op;
    in_rd_addr = rd; in_reg_write = 1;
  endtask

  task automatic rand_cycle();
    in_valid     = ($urandom_range(0, 3) != 0);
    in_rs_addr   = 5'($urandom_range(0, 3));
    in_rt_addr   = 5'($urandom_range(0, 3));
    in_rs_data   = $urandom;
    in_rt_data   = $urandom;
    in_imm       = $urandom;
    in_alu_src   = 1'($urandom_range(0, 1));
    in_alu_op    = 4'($urandom_range(0, 15));
    in_rd_addr   = 5'($urandom_range(0, 31));
    in_reg_write = 1'($urandom_range(0, 1));
    flush        = ($urandom_range(0, 15) == 0);
    exmem_wr     = 1'($urandom_range(0, 1));
    exmem_rd     = 5'($urandom_range(0, 3));
    exmem_result = $urandom;
    memwb_wr     = 1'($urandom_range(0, 1));
    memwb_rd     = 5'($urandom_range(0, 3));
    memwb_result = $urandom;
    out_ready    = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    rst = 1; out_ready = 0;
    idle();
    in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0; in_rs_data = 0; in_rt_data = 0;
    in_imm = 0; in_alu_src = 0; in_alu_op = 0; in_reg_write = 0;
    exmem_rd = 0; memwb_rd = 0; exmem_result = 0; memwb_result = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_alu_op", 64'(alu_op), 64'(OP_ADD));
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_rd", 64'(out_rd_addr), 64'd0);
    chk("rst_reg_write", 64'(out_reg_write), 64'd0);
    @(negedge clk);

    // Streaming, one op per cycle.
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      set_op(1, 5 + i, 2, 7, 0, 0, OP_SUB, 5'(i + 3));
      tick();
    end
    idle(); tick(); tick();

    // Skid fill then drain.
    out_ready = 0;
    set_op(1, 32'h100, 2, 32'h200, 0, 0, OP_ADD, 4); tick();
    set_op(2, 32'h300, 3, 32'h400, 32'h55, 1, OP_SUB, 5); tick();
    idle(); tick();
    out_ready = 1; tick(); tick(); tick();

    // Flush with two held ops and a concurrent push.
    out_ready = 0;
    set_op(1, 32'hA1, 2, 32'hA2, 0, 0, OP_ADD, 6); tick();
    set_op(1, 32'hB1, 2, 32'hB2, 0, 0, OP_SUB, 7); tick();
    set_op(1, 32'hC1, 2, 32'hC2, 0, 0, OP_ADD, 8); flush = 1; tick();
    idle(); out_ready = 1; tick(); tick(); tick();

`ifdef OPSTAGE_FWD_EN
    out_ready = 1;
    set_op(3, 32'h99, 1, 32'h1, 0, 0, OP_ADD, 9);
    exmem_wr = 1; exmem_rd = 3; exmem_result = 32'h11;
    memwb_wr = 1; memwb_rd = 3; memwb_result = 32'h22;
    tick();
    exmem_wr = 0; tick();
    set_op(0, 32'h77, 1, 32'h1, 0, 0, OP_ADD, 9);
    exmem_wr = 1; exmem_rd = 0; memwb_wr = 1; memwb_rd = 0; tick();
    idle(); tick(); tick();

    out_ready = 0;
    set_op(1, 32'h1, 4, 32'h44, 32'h55, 0, OP_ADD, 10); tick();
    idle(); exmem_wr = 1; exmem_rd = 4; exmem_result = 32'hABCD; tick();
    idle(); out_ready = 1; tick(); tick();
    out_ready = 0;
    set_op(1, 32'h1, 4, 32'h44, 32'h55, 1, OP_ADD, 11); tick();
    idle(); exmem_wr = 1; exmem_rd = 4; exmem_result = 32'hABCD; tick();
    idle(); out_ready = 1; tick(); tick();
`endif

    for (int i = 0; i < 400; i++) begin
      rand_cycle();
      tick();
    end
    idle(); out_ready = 1; tick(); tick(); tick();

    // Asynchronous reset with two ops held.
    out_ready = 0;
    set_op(1, 32'hD1, 2, 32'hD2, 0, 0, OP_SUB, 12); tick();
    set_op(1, 32'hE1, 2, 32'hE2, 0, 0, OP_SUB, 13); tick();
    idle(); tick();
    rst = 1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_alu_op", 64'(alu_op), 64'(OP_ADD));
    mq.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    repeat (5) tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
